// File: rtl/led_pkg.sv
// Shared encodings for the LED controller: pattern modes, register map,
// bus FSM states and STATUS word layout.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_OFF    = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_MODE   = 2'd1,
        REG_PERIOD = 2'd2,
        REG_STATUS = 2'd3
    } led_reg_e;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_ACK  = 1'b1
    } bus_state_e;

    // STATUS word: [LED_WIDTH-1:0] last LED value, [8] blink phase, [10:9] mode.
    localparam int STATUS_PHASE_BIT = 8;
    localparam int STATUS_MODE_LSB  = 9;

endpackage

// File: rtl/led_ctrl_if.sv
// Valid/ready register-access bus between a CPU-side requester and led_ctrl.
interface led_ctrl_if;

    logic        bus_valid;
    logic        bus_write;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_valid, bus_write, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_valid, bus_write, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );

endinterface

// File: rtl/led_tick_counter.sv
// Pattern-engine period counter: counts down from the effective period and
// flags an expiry when it reaches 1, then reloads. A period of 0 acts as 1.
module led_tick_counter #(
    parameter int                      PERIOD_WIDTH = 24,
    parameter logic [PERIOD_WIDTH-1:0] RESET_PERIOD = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    enable_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    output logic                    expire_o
);

    logic [PERIOD_WIDTH-1:0] cnt_q;
    logic [PERIOD_WIDTH-1:0] reload;

    function automatic logic [PERIOD_WIDTH-1:0] eff_period(input logic [PERIOD_WIDTH-1:0] p);
        return (p == '0) ? PERIOD_WIDTH'(1) : p;
    endfunction

    assign reload = eff_period(period_i);

    // A load in the same cycle swallows the expiry: the count restarts from scratch.
    assign expire_o = enable_i && !load_i && (cnt_q <= PERIOD_WIDTH'(1));

    // Countdown with reload on explicit load or on expiry; holds when disabled.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments and the reset is
        // sampled synchronously inside the clocked block.
        if (!rst_n) begin
            cnt_q <= eff_period(RESET_PERIOD);
        end else if (load_i || expire_o) begin
            cnt_q <= reload;
        end else if (enable_i) begin
            cnt_q <= cnt_q - PERIOD_WIDTH'(1);
        end
    end

endmodule

// File: rtl/led_ctrl.sv
// LED register controller: CPU register file behind a valid/ready bus, a
// pattern engine (static/blink/rotate/off) and a single-strobe LED write port.
module led_ctrl
    import led_pkg::*;
#(
    parameter int                      LED_WIDTH      = 6,
    parameter int                      PERIOD_WIDTH   = 24,
    parameter logic [PERIOD_WIDTH-1:0] DEFAULT_PERIOD = 24'd1000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_ctrl_if.slave            bus,
    output logic                 led_we,
    output logic [LED_WIDTH-1:0] led_data
);

    bus_state_e               state_q;
    logic                     ready_q;
    logic [31:0]              rdata_q;

    logic [LED_WIDTH-1:0]     data_q,   data_d;
    logic [LED_WIDTH-1:0]     shadow_q, shadow_d;
    logic [LED_WIDTH-1:0]     led_data_q, led_data_d;
    led_mode_e                mode_q,   mode_d;
    logic [PERIOD_WIDTH-1:0]  period_q, period_d;
    logic                     phase_q,  phase_d;
    logic                     led_we_q, led_we_d;
    logic                     init_q;

    logic                     accept;
    logic                     ctr_load;
    logic                     ctr_enable;
    logic                     expire;
    logic                     strobe;
    led_reg_e                 sel;
    logic [LED_WIDTH-1:0]     out_val;
    logic [31:0]              status_word;
    logic [31:0]              read_word;
    logic                     unused_wdata;

    assign sel        = led_reg_e'(bus.bus_addr);
    assign accept     = (state_q == BUS_IDLE) && bus.bus_valid;
    assign ctr_load   = accept && bus.bus_write && (sel != REG_STATUS);
    assign ctr_enable = (mode_q == MODE_BLINK) || (mode_q == MODE_ROTATE);
    assign unused_wdata = ^bus.bus_wdata;

    led_tick_counter #(
        .PERIOD_WIDTH (PERIOD_WIDTH),
        .RESET_PERIOD (DEFAULT_PERIOD)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (ctr_load),
        .enable_i (ctr_enable),
        .period_i (period_d),
        .expire_o (expire)
    );

    // Register-file next state: committed writes win over engine expiries.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned
        // (which would infer a latch).
        data_d   = data_q;
        shadow_d = shadow_q;
        mode_d   = mode_q;
        period_d = period_q;
        phase_d  = phase_q;
        strobe   = 1'b0;
        if (ctr_load) begin
            case (sel)
                REG_DATA: begin
                    data_d   = bus.bus_wdata[LED_WIDTH-1:0];
                    shadow_d = bus.bus_wdata[LED_WIDTH-1:0];
                    phase_d  = 1'b1;
                    strobe   = 1'b1;
                end
                REG_MODE: begin
                    mode_d   = led_mode_e'(bus.bus_wdata[1:0]);
                    shadow_d = data_q;
                    phase_d  = 1'b1;
                    strobe   = 1'b1;
                end
                REG_PERIOD: period_d = bus.bus_wdata[PERIOD_WIDTH-1:0];
                default: ;
            endcase
        end else if (expire) begin
            if (mode_q == MODE_BLINK) begin
                phase_d = ~phase_q;
            end else begin
                shadow_d = {shadow_q[LED_WIDTH-2:0], shadow_q[LED_WIDTH-1]};
            end
            strobe = 1'b1;
        end
    end

    // Output mux: LED value implied by the next mode/data/phase/shadow.
    always_comb begin
        case (mode_d)
            MODE_STATIC: out_val = data_d;
            MODE_BLINK:  out_val = phase_d ? data_d : '0;
            MODE_ROTATE: out_val = shadow_d;
            default:     out_val = '0;
        endcase
        led_we_d   = strobe || init_q;
        led_data_d = strobe ? out_val : (init_q ? '0 : led_data_q);
    end

    // Read mux; values are the ones held before the accepting edge.
    always_comb begin
        status_word = '0;
        status_word[LED_WIDTH-1:0]                       = led_data_q;
        status_word[STATUS_PHASE_BIT]                    = phase_q;
        status_word[STATUS_MODE_LSB+1:STATUS_MODE_LSB]   = mode_q;
        case (sel)
            REG_DATA:   read_word = 32'(data_q);
            REG_MODE:   read_word = 32'(mode_q);
            REG_PERIOD: read_word = 32'(period_q);
            default:    read_word = status_word;
        endcase
    end

    // Bus FSM: one ACK cycle per accepted access, requests ignored during ACK.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BUS_IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                BUS_IDLE: begin
                    if (bus.bus_valid) begin
                        state_q <= BUS_ACK;
                        ready_q <= 1'b1;
                        rdata_q <= read_word;
                    end
                end
                default: begin
                    state_q <= BUS_IDLE;
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    // Register file and LED write port; init_q requests one zero write after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q     <= '0;
            shadow_q   <= '0;
            mode_q     <= MODE_STATIC;
            period_q   <= DEFAULT_PERIOD;
            phase_q    <= 1'b1;
            led_we_q   <= 1'b0;
            led_data_q <= '0;
            init_q     <= 1'b1;
        end else begin
            data_q     <= data_d;
            shadow_q   <= shadow_d;
            mode_q     <= mode_d;
            period_q   <= period_d;
            phase_q    <= phase_d;
            led_we_q   <= led_we_d;
            led_data_q <= led_data_d;
            init_q     <= 1'b0;
        end
    end

    assign bus.bus_ready = ready_q;
    assign bus.bus_rdata = rdata_q;
    assign led_we        = led_we_q;
    assign led_data      = led_data_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Self-checking bench for led_ctrl: register access table plus timed
// sequences for blink, rotate, write/expiry collision and reset.
module tb_led_ctrl;
    import led_pkg::*;

    localparam int LW = 6;
    localparam int PW = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    led_ctrl_if bus ();
    logic          led_we;
    logic [LW-1:0] led_data;

    led_ctrl #(
        .LED_WIDTH      (LW),
        .PERIOD_WIDTH   (PW),
        .DEFAULT_PERIOD (24'd1000000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .led_we   (led_we),
        .led_data (led_data)
    );

    // Edge counter and LED strobe recorder (sampled on the falling edge).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [LW-1:0] data;
    } strobe_t;
    strobe_t strobes[$];
    always @(negedge clk) if (led_we === 1'b1) strobes.push_back('{cyc, led_data});

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus access; outputs are sampled in the ACK cycle and one cycle later.
    task automatic bus_access(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                              output int acc, output logic rdy, output logic [31:0] rd,
                              output logic we, output logic [LW-1:0] ld, output logic rdy_after);
        bus.bus_valid = 1'b1;
        bus.bus_write = wr;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        @(posedge clk);
        #1;
        acc = cyc;
        rdy = bus.bus_ready;
        rd  = bus.bus_rdata;
        we  = led_we;
        ld  = led_data;
        bus.bus_valid = 1'b0;
        bus.bus_write = 1'b0;
        @(posedge clk);
        #1;
        rdy_after = bus.bus_ready;
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [31:0] wdata, output int acc);
        logic r, w, ra;
        logic [31:0] d;
        logic [LW-1:0] l;
        bus_access(1'b1, addr, wdata, acc, r, d, w, l, ra);
    endtask

    task automatic read_check(input string name, input logic [1:0] addr, input logic [31:0] exp);
        int a;
        logic r, w, ra;
        logic [31:0] d;
        logic [LW-1:0] l;
        bus_access(1'b0, addr, 32'h0, a, r, d, w, l, ra);
        check({name, " ready"}, 32'(r), 32'd1);
        check({name, " rdata"}, d, exp);
    endtask

    // Compare recorded strobes from cycle 'base' onward against an evenly spaced list.
    task automatic check_strobes(input string name, input int base, input int step,
                                 input logic [LW-1:0] exp[$]);
        strobe_t got[$];
        foreach (strobes[i]) if (strobes[i].cyc >= base) got.push_back(strobes[i]);
        check({name, " count"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            check($sformatf("%s[%0d] cycle", name, i), 32'(got[i].cyc - base), 32'(i * step));
            check($sformatf("%s[%0d] data", name, i), 32'(got[i].data), 32'(exp[i]));
        end
    endtask

    typedef struct {
        logic          wr;
        logic [1:0]    addr;
        logic [31:0]   wdata;
        logic          exp_we;
        logic [LW-1:0] exp_led;
        logic [31:0]   exp_rdata;
    } vec_t;

    vec_t vecs[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, c0;
        logic rdy, we, rdy_after;
        logic [31:0] rd;
        logic [LW-1:0] ld;
        logic [LW-1:0] exp_q[$];

        //            wr    addr  wdata          we    led    rdata
        vecs[0]  = '{1'b1, 2'd0, 32'h0000_0001, 1'b1, 6'h01, 32'h0};
        vecs[1]  = '{1'b0, 2'd0, 32'h0,         1'b0, 6'h01, 32'h0000_0001};
        vecs[2]  = '{1'b0, 2'd1, 32'h0,         1'b0, 6'h01, 32'h0000_0000};
        vecs[3]  = '{1'b0, 2'd2, 32'h0,         1'b0, 6'h01, 32'd1000000};
        vecs[4]  = '{1'b1, 2'd2, 32'h1234_5678, 1'b0, 6'h01, 32'h0};
        vecs[5]  = '{1'b0, 2'd2, 32'h0,         1'b0, 6'h01, 32'h0034_5678};
        vecs[6]  = '{1'b0, 2'd3, 32'h0,         1'b0, 6'h01, 32'h0000_0101};
        vecs[7]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 6'h01, 32'h0};
        vecs[8]  = '{1'b1, 2'd0, 32'hFFFF_FFEA, 1'b1, 6'h2A, 32'h0};
        vecs[9]  = '{1'b1, 2'd1, 32'h0000_0003, 1'b1, 6'h00, 32'h0};
        vecs[10] = '{1'b0, 2'd3, 32'h0,         1'b0, 6'h00, 32'h0000_0700};
        vecs[11] = '{1'b1, 2'd1, 32'h0000_0000, 1'b1, 6'h2A, 32'h0};
        vecs[12] = '{1'b0, 2'd1, 32'h0,         1'b0, 6'h2A, 32'h0000_0000};
        vecs[13] = '{1'b0, 2'd0, 32'h0,         1'b0, 6'h2A, 32'h0000_002A};

        bus.bus_valid = 1'b0;
        bus.bus_write = 1'b0;
        bus.bus_addr  = 2'd0;
        bus.bus_wdata = 32'h0;

        // Reset state and init sync strobe.
        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 32'(bus.bus_ready), 32'd0);
        check("reset rdata", bus.bus_rdata, 32'h0);
        check("reset led_we", 32'(led_we), 32'd0);
        check("reset led_data", 32'(led_data), 32'd0);
        strobes.delete();
        rst_n = 1'b1;
        c0 = cyc;
        wait_until(c0 + 1);
        check("init led_we", 32'(led_we), 32'd1);
        check("init led_data", 32'(led_data), 32'd0);
        check("init ready", 32'(bus.bus_ready), 32'd0);
        wait_until(c0 + 2);
        check("init led_we drop", 32'(led_we), 32'd0);
        wait_until(c0 + 6);
        check("init strobe count", 32'(strobes.size()), 32'd1);
        read_check("init STATUS", 2'd3, 32'h0000_0100);

        // Register access table (STATIC / OFF modes, no engine activity).
        foreach (vecs[i]) begin
            bus_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, a, rdy, rd, we, ld, rdy_after);
            check($sformatf("vec%0d ready", i), 32'(rdy), 32'd1);
            check($sformatf("vec%0d led_we", i), 32'(we), 32'(vecs[i].exp_we));
            check($sformatf("vec%0d led_data", i), 32'(ld), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d ready drop", i), 32'(rdy_after), 32'd0);
            if (!vecs[i].wr) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
        end

        // STATIC is quiet.
        strobes.delete();
        repeat (100) @(posedge clk);
        #1;
        check("static quiet", 32'(strobes.size()), 32'd0);

        // BLINK, PERIOD=4.
        write_reg(2'd2, 32'd4, a);
        write_reg(2'd0, 32'h0A, a);
        write_reg(2'd1, 32'd1, n);
        wait_until(n + 13);
        exp_q = '{6'h0A, 6'h00, 6'h0A, 6'h00};
        check_strobes("blink4", n, 4, exp_q);

        // ROTATE, PERIOD=2, MSB wraps to LSB.
        write_reg(2'd2, 32'd2, a);
        write_reg(2'd0, 32'h21, a);
        write_reg(2'd1, 32'd2, n);
        wait_until(n + 13);
        exp_q = '{6'h21, 6'h03, 6'h06, 6'h0C, 6'h18, 6'h30, 6'h21};
        check_strobes("rotate2", n, 2, exp_q);

        // DATA write on an expiry edge: one strobe with new DATA, restart of period.
        write_reg(2'd2, 32'd3, a);
        write_reg(2'd1, 32'd2, n);
        wait_until(n + 2);
        bus_access(1'b1, 2'd0, 32'h3C, a, rdy, rd, we, ld, rdy_after);
        check("arb led_data", 32'(ld), 32'h3C);
        wait_until(n + 7);
        exp_q = '{6'h21, 6'h3C, 6'h39};
        check_strobes("arb", n, 3, exp_q);

        // Reset during ACK while rotating.
        bus.bus_valid = 1'b1;
        bus.bus_write = 1'b1;
        bus.bus_addr  = 2'd0;
        bus.bus_wdata = 32'h3F;
        @(posedge clk);
        #1;
        check("pre-reset ack", 32'(bus.bus_ready), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst ack ready", 32'(bus.bus_ready), 32'd0);
        check("rst ack rdata", bus.bus_rdata, 32'h0);
        check("rst ack led_we", 32'(led_we), 32'd0);
        check("rst ack led_data", 32'(led_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst held ready", 32'(bus.bus_ready), 32'd0);
        bus.bus_valid = 1'b0;
        bus.bus_write = 1'b0;
        strobes.delete();
        rst_n = 1'b1;
        c0 = cyc;
        wait_until(c0 + 1);
        check("re-init led_we", 32'(led_we), 32'd1);
        check("re-init led_data", 32'(led_data), 32'd0);
        wait_until(c0 + 8);
        check("re-init strobe count", 32'(strobes.size()), 32'd1);
        read_check("post-rst DATA", 2'd0, 32'h0);
        read_check("post-rst MODE", 2'd1, 32'h0);
        read_check("post-rst PERIOD", 2'd2, 32'd1000000);
        read_check("post-rst STATUS", 2'd3, 32'h0000_0100);

        // BLINK with PERIOD=0 toggles every cycle.
        write_reg(2'd2, 32'd0, a);
        write_reg(2'd0, 32'h15, a);
        write_reg(2'd1, 32'd1, n);
        wait_until(n + 5);
        exp_q = '{6'h15, 6'h00, 6'h15, 6'h00, 6'h15};
        check_strobes("blink0", n, 1, exp_q);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
